// File: rtl/sdram_line_fetcher.sv
// sdram_line_fetcher
//   Fetches one video scanline from the SDRAM arbiter's video port for each
//   accepted line_start pulse. The line is read as back-to-back bursts of
//   BURST_LEN words over the rd/rdy/ack handshake, and every returned word is
//   written into a line-buffer write port.
//
// Ports
//   clk_i, rst_ni        system clock, synchronous active-low reset
//   line_start_i         pulse: begin fetching a line (accepted only when idle)
//   line_base_i[23:0]    x16 word address of the first word, sampled on accept
//   busy_o               fetch in progress
//   done_o               one-cycle pulse after the last buffer write
//   overrun_o            sticky: line_start_i seen while busy (reset clears)
//   sdram_rd_o           burst request, held for the whole burst
//   sdram_addr_x16_o     burst start address, stable for the whole burst
//   sdram_ack_o          one-cycle burst acknowledge
//   sdram_rdy_i          one valid data word per high cycle
//   sdram_rdata_i[15:0]  returned data word
//   buf_we_o             line-buffer write enable
//   buf_waddr_o          line-buffer word index, 0..LINE_WORDS-1
//   buf_wdata_o[15:0]    line-buffer write data
module sdram_line_fetcher #(
  parameter int LINE_WORDS = 320,
  parameter int BURST_LEN  = 8,
  parameter int BUF_AW     = 9
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              line_start_i,
  input  logic [23:0]       line_base_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              overrun_o,
  output logic              sdram_rd_o,
  output logic [23:0]       sdram_addr_x16_o,
  output logic              sdram_ack_o,
  input  logic              sdram_rdy_i,
  input  logic [15:0]       sdram_rdata_i,
  output logic              buf_we_o,
  output logic [BUF_AW-1:0] buf_waddr_o,
  output logic [15:0]       buf_wdata_o
);

  // One extra index bit so the counter can hold LINE_WORDS itself.
  localparam int IW = BUF_AW + 1;
  localparam int BW = $clog2(BURST_LEN);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] ACK  = 2'd2;

  localparam logic [IW-1:0] LINE_END  = IW'(LINE_WORDS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);
  localparam logic [23:0]   ADDR_STEP = 24'(BURST_LEN);

  if ((LINE_WORDS <= 0) || ((LINE_WORDS % BURST_LEN) != 0)) begin : g_chk_line
    $error("sdram_line_fetcher: LINE_WORDS must be a positive multiple of BURST_LEN");
  end
  if ((BURST_LEN < 2) || (BURST_LEN > 64) || ((BURST_LEN & (BURST_LEN - 1)) != 0)) begin : g_chk_burst
    $error("sdram_line_fetcher: BURST_LEN must be a power of two in 2..64");
  end
  if ((1 << BUF_AW) < LINE_WORDS) begin : g_chk_aw
    $error("sdram_line_fetcher: 2**BUF_AW must be >= LINE_WORDS");
  end

  logic [1:0]        state;
  logic [IW-1:0]     idx;
  logic [BW-1:0]     beat;
  logic              rd;
  logic              ack;
  logic [23:0]       addr;
  logic              we;
  logic [BUF_AW-1:0] waddr;
  logic [15:0]       wdata;
  logic              done;
  logic              overrun;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state   <= IDLE;
      idx     <= '0;
      beat    <= '0;
      rd      <= 1'b0;
      ack     <= 1'b0;
      addr    <= '0;
      we      <= 1'b0;
      waddr   <= '0;
      wdata   <= '0;
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      we   <= 1'b0;
      done <= 1'b0;

      if (line_start_i && (state != IDLE)) begin
        overrun <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (line_start_i) begin
            state <= REQ;
            rd    <= 1'b1;
            addr  <= line_base_i;
            idx   <= '0;
            beat  <= '0;
          end
        end

        REQ: begin
          if (sdram_rdy_i) begin
            we    <= 1'b1;
            waddr <= idx[BUF_AW-1:0];
            wdata <= sdram_rdata_i;
            idx   <= idx + IW'(1);
            beat  <= beat + BW'(1);
            // Drop rd on the same edge that raises ack so they never overlap.
            if (beat == LAST_BEAT) begin
              state <= ACK;
              rd    <= 1'b0;
              ack   <= 1'b1;
            end
          end
        end

        ACK: begin
          ack <= 1'b0;
          if (idx < LINE_END) begin
            state <= REQ;
            rd    <= 1'b1;
            addr  <= addr + ADDR_STEP;
            beat  <= '0;
          end else begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          rd    <= 1'b0;
          ack   <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o           = (state != IDLE);
  assign done_o           = done;
  assign overrun_o        = overrun;
  assign sdram_rd_o       = rd;
  assign sdram_addr_x16_o = addr;
  assign sdram_ack_o      = ack;
  assign buf_we_o         = we;
  assign buf_waddr_o      = waddr;
  assign buf_wdata_o      = wdata;

endmodule

// File: tb/tb_sdram_line_fetcher.sv
// Bench for sdram_line_fetcher: an arbiter model answers bursts with words
// derived from the requested address; expected buffer writes and burst
// addresses are queued when a line is started and checked as they appear.
module tb_sdram_line_fetcher;

  localparam int LW = 16;
  localparam int BL = 8;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          line_start = 1'b0;
  logic [23:0]   line_base = '0;
  logic          busy, done, overrun;
  logic          sdram_rd, sdram_ack;
  logic [23:0]   sdram_addr;
  logic          sdram_rdy = 1'b0;
  logic [15:0]   sdram_rdata = '0;
  logic          buf_we;
  logic [AW-1:0] buf_waddr;
  logic [15:0]   buf_wdata;

  always #5 clk = ~clk;

  sdram_line_fetcher #(
    .LINE_WORDS(LW),
    .BURST_LEN (BL),
    .BUF_AW    (AW)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .line_start_i    (line_start),
    .line_base_i     (line_base),
    .busy_o          (busy),
    .done_o          (done),
    .overrun_o       (overrun),
    .sdram_rd_o      (sdram_rd),
    .sdram_addr_x16_o(sdram_addr),
    .sdram_ack_o     (sdram_ack),
    .sdram_rdy_i     (sdram_rdy),
    .sdram_rdata_i   (sdram_rdata),
    .buf_we_o        (buf_we),
    .buf_waddr_o     (buf_waddr),
    .buf_wdata_o     (buf_wdata)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [15:0]   d;
  } wr_t;

  wr_t         wr_q[$];
  logic [23:0] addr_q[$];

  int tests_run = 0;
  int tests_failed = 0;
  int writes_seen = 0;
  int acks_seen = 0;
  int dones_seen = 0;
  int beats_given = 0;
  int stall_pct = 0;

  int          mstate = 0;
  int          waitcnt = 0;
  int          beat = 0;
  logic [23:0] cur_addr = '0;
  logic        s_rdy = 1'b0;
  logic        s_rstn = 1'b0;

  function automatic logic [15:0] mem_word(input logic [23:0] a);
    return a[15:0] ^ {a[23:16], a[23:16]} ^ 16'h5A3C;
  endfunction

  // Values the DUT saw at the last rising edge.
  always @(posedge clk) begin
    s_rdy  <= sdram_rdy;
    s_rstn <= rst_n;
  end

  // Write/handshake monitor and arbiter model, both on the falling edge.
  initial begin
    wr_t         w;
    logic [23:0] ea;
    forever begin
      @(negedge clk);
      tests_run++;
      if (buf_we !== (s_rdy & s_rstn)) begin
        tests_failed++;
        $display("FAIL we_timing: buf_we=%b expected %b", buf_we, s_rdy & s_rstn);
      end
      if ((sdram_rd === 1'b1) && (sdram_ack === 1'b1)) begin
        tests_failed++;
        $display("FAIL rd_ack_overlap: rd=1 ack=1 expected not both");
      end
      if (buf_we === 1'b1) begin
        writes_seen++;
        tests_run++;
        if (wr_q.size() == 0) begin
          tests_failed++;
          $display("FAIL unexpected_write: waddr=%0d data=%h expected no write", buf_waddr, buf_wdata);
        end else begin
          w = wr_q.pop_front();
          if ((buf_waddr !== w.a) || (buf_wdata !== w.d)) begin
            tests_failed++;
            $display("FAIL buf_write: waddr=%0d data=%h expected waddr=%0d data=%h",
                     buf_waddr, buf_wdata, w.a, w.d);
          end
        end
      end
      if (sdram_ack === 1'b1) acks_seen++;
      if (done === 1'b1) dones_seen++;

      if (!rst_n) begin
        mstate    = 0;
        sdram_rdy = 1'b0;
        beat      = 0;
      end else begin
        case (mstate)
          0: begin
            sdram_rdy = 1'b0;
            if (sdram_rd === 1'b1) begin
              tests_run++;
              if (addr_q.size() == 0) begin
                tests_failed++;
                $display("FAIL unexpected_burst: addr=%h expected no burst", sdram_addr);
              end else begin
                ea = addr_q.pop_front();
                if (sdram_addr !== ea) begin
                  tests_failed++;
                  $display("FAIL burst_addr: addr=%h expected %h", sdram_addr, ea);
                end
              end
              cur_addr = sdram_addr;
              beat     = 0;
              waitcnt  = 1;
              mstate   = 1;
            end
          end
          1: begin
            tests_run++;
            if ((sdram_rd !== 1'b1) || (sdram_addr !== cur_addr)) begin
              tests_failed++;
              $display("FAIL rd_hold: rd=%b addr=%h expected rd=1 addr=%h", sdram_rd, sdram_addr, cur_addr);
            end
            if (waitcnt > 0) begin
              waitcnt--;
              sdram_rdy = 1'b0;
            end else if ((stall_pct != 0) && ($urandom_range(99) < stall_pct)) begin
              sdram_rdy = 1'b0;
            end else begin
              sdram_rdy   = 1'b1;
              sdram_rdata = mem_word(cur_addr + 24'(beat));
              beat++;
              beats_given++;
              if (beat == BL) mstate = 2;
            end
          end
          default: begin
            sdram_rdy = 1'b0;
            if (sdram_ack === 1'b1) mstate = 0;
          end
        endcase
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_expect(input logic [23:0] base);
    logic [23:0] a;
    for (int i = 0; i < LW; i++) begin
      a = base + 24'(i);
      wr_q.push_back({AW'(i), mem_word(a)});
    end
    for (int b = 0; b < LW / BL; b++) begin
      addr_q.push_back(base + 24'(b * BL));
    end
  endtask

  task automatic start_line(input logic [23:0] base);
    step();
    line_start = 1'b1;
    line_base  = base;
    push_expect(base);
    step();
    line_start = 1'b0;
    line_base  = ~base;
  endtask

  task automatic wait_done(input string name);
    int d0 = dones_seen;
    int n = 0;
    while ((dones_seen == d0) && (n < 600)) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    tests_run++;
    if (dones_seen == d0) begin
      tests_failed++;
      $display("FAIL %s_timeout: done not seen after %0d cycles expected done", name, n);
    end
  endtask

  task automatic wait_beats(input int target);
    int n = 0;
    while ((beats_given < target) && (n < 200)) begin
      @(posedge clk);
      n++;
    end
    tests_run++;
    if (beats_given < target) begin
      tests_failed++;
      $display("FAIL beat_wait_timeout: beats=%0d expected %0d", beats_given, target);
    end
  endtask

  task automatic check_line(input string name, input int w0, input int a0, input int d0, input int lines);
    tests_run++;
    if ((writes_seen - w0) != lines * LW) begin
      tests_failed++;
      $display("FAIL %s_writes: got %0d expected %0d", name, writes_seen - w0, lines * LW);
    end
    tests_run++;
    if ((acks_seen - a0) != lines * (LW / BL)) begin
      tests_failed++;
      $display("FAIL %s_acks: got %0d expected %0d", name, acks_seen - a0, lines * (LW / BL));
    end
    tests_run++;
    if ((dones_seen - d0) != lines) begin
      tests_failed++;
      $display("FAIL %s_dones: got %0d expected %0d", name, dones_seen - d0, lines);
    end
    tests_run++;
    if ((wr_q.size() != 0) || (addr_q.size() != 0)) begin
      tests_failed++;
      $display("FAIL %s_pending: writes=%0d bursts=%0d expected 0 0", name, wr_q.size(), addr_q.size());
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_idle: busy=%b expected 0", name, busy);
    end
  endtask

  task automatic run_line(input string name, input logic [23:0] base, input int stall);
    int w0 = writes_seen;
    int a0 = acks_seen;
    int d0 = dones_seen;
    stall_pct = stall;
    start_line(base);
    wait_done(name);
    check_line(name, w0, a0, d0, 1);
    stall_pct = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    @(negedge clk);
    tests_run++;
    if ({busy, done, overrun, sdram_rd, sdram_ack, buf_we} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: busy/done/ovr/rd/ack/we=%b expected 000000",
               {busy, done, overrun, sdram_rd, sdram_ack, buf_we});
    end
    tests_run++;
    if ({sdram_addr, buf_waddr, buf_wdata} !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: addr=%h waddr=%h wdata=%h expected 0", sdram_addr, buf_waddr, buf_wdata);
    end
    step();
    rst_n = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_basic();
    run_line("basic", 24'h000100, 0);
    tests_run++;
    if (overrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_overrun: overrun=%b expected 0", overrun);
    end
  endtask

  task automatic test_stalls();
    run_line("stalls", 24'h000100, 30);
  endtask

  task automatic test_wrap();
    run_line("wrap", 24'hFFFFF8, 0);
  endtask

  task automatic test_back_to_back();
    int w0 = writes_seen;
    int a0 = acks_seen;
    int d0 = dones_seen;
    int n = 0;
    start_line(24'h000500);
    while ((done !== 1'b1) && (n < 600)) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (done !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_done_timeout: done=%b expected 1", done);
    end
    line_start = 1'b1;
    line_base  = 24'h000600;
    push_expect(24'h000600);
    @(posedge clk);
    #2;
    line_start = 1'b0;
    line_base  = 24'h0;
    @(negedge clk);
    tests_run++;
    if ((sdram_rd !== 1'b1) || (sdram_addr !== 24'h000600)) begin
      tests_failed++;
      $display("FAIL b2b_restart: rd=%b addr=%h expected rd=1 addr=000600", sdram_rd, sdram_addr);
    end
    tests_run++;
    if (overrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_overrun: overrun=%b expected 0", overrun);
    end
    wait_done("b2b");
    check_line("b2b", w0, a0, d0, 2);
  endtask

  task automatic test_overrun();
    int w0 = writes_seen;
    int a0 = acks_seen;
    int d0 = dones_seen;
    beats_given = 0;
    start_line(24'h000400);
    wait_beats(3);
    #2;
    line_start = 1'b1;
    line_base  = 24'h123456;
    step();
    line_start = 1'b0;
    @(negedge clk);
    tests_run++;
    if (overrun !== 1'b1) begin
      tests_failed++;
      $display("FAIL overrun_set: overrun=%b expected 1", overrun);
    end
    wait_done("overrun");
    check_line("overrun", w0, a0, d0, 1);
    repeat (5) @(negedge clk);
    tests_run++;
    if ((overrun !== 1'b1) || (sdram_rd !== 1'b0) || (busy !== 1'b0)) begin
      tests_failed++;
      $display("FAIL overrun_sticky: overrun=%b rd=%b busy=%b expected 1 0 0", overrun, sdram_rd, busy);
    end
  endtask

  task automatic test_reset_mid();
    beats_given = 0;
    start_line(24'h000200);
    wait_beats(3);
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({sdram_rd, sdram_ack, buf_we, busy, overrun} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_mid: rd/ack/we/busy/ovr=%b expected 00000",
               {sdram_rd, sdram_ack, buf_we, busy, overrun});
    end
    wr_q.delete();
    addr_q.delete();
    step();
    rst_n = 1'b1;
    repeat (2) step();
    run_line("after_reset", 24'h000300, 0);
    tests_run++;
    if (overrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL after_reset_overrun: overrun=%b expected 0", overrun);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stalls();
    test_wrap();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
